// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_gather serial-in/parallel-out collector.
package fifo_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } gather_state_t;

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_gather_bank.sv
// DEPTH x BITS register bank: shift toward index 0 or parallel capture.
// Element [0] is the oldest word; new words enter at [DEPTH-1].
module fifo_gather_bank #(
    parameter int DEPTH = 8,
    parameter int BITS  = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        shift,
    input  logic [BITS-1:0]             shift_in,
    input  logic                        load,
    input  logic [DEPTH-1:0][BITS-1:0]  load_data,
    output logic [DEPTH-1:0][BITS-1:0]  q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {shift_in, q[DEPTH-1:1]};
        end
    end

endmodule

// File: rtl/fifo_gather.sv
// Serial-in, parallel-out collector for one systolic-array output lane.
// Optional hold bank (decoupling collection from the consumer): FIFO_GATHER_DOUBLE_BUF_EN.
module fifo_gather
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int BITS  = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clr,
    input  logic                               en,
    input  logic [BITS-1:0]                    d,
    output logic                               in_ready,
    output logic [DEPTH-1:0][BITS-1:0]         out_array,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [count_width(DEPTH)-1:0]      count,
    output logic                               overflow
);

    localparam int             CW         = count_width(DEPTH);
    localparam logic [CW-1:0]  COUNT_LAST = CW'(DEPTH - 1);

    gather_state_t              state;
    gather_state_t              state_next;
    logic [CW-1:0]              count_next;
    logic [DEPTH-1:0][BITS-1:0] regs;
    logic                       release_vec;
    logic                       accept;
    logic                       drop;

    assign in_ready = (state == FILL) || release_vec;
    assign accept   = en && in_ready && !clr;
    assign drop     = en && !in_ready && !clr;

    fifo_gather_bank #(
        .DEPTH (DEPTH),
        .BITS  (BITS)
    ) u_shift_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .shift     (accept),
        .shift_in  (d),
        .load      (1'b0),
        .load_data ('0),
        .q         (regs)
    );

`ifdef FIFO_GATHER_DOUBLE_BUF_EN
    logic [DEPTH-1:0][BITS-1:0] hold_regs;
    logic                       hold_valid;

    // A full shift bank moves to the hold bank whenever the hold bank is free or being drained.
    assign release_vec = (state == FULL) && (!hold_valid || out_ready);

    fifo_gather_bank #(
        .DEPTH (DEPTH),
        .BITS  (BITS)
    ) u_hold_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .shift     (1'b0),
        .shift_in  ('0),
        .load      (release_vec),
        .load_data (regs),
        .q         (hold_regs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
        end else if (clr) begin
            hold_valid <= 1'b0;
        end else if (release_vec) begin
            hold_valid <= 1'b1;
        end else if (out_ready) begin
            hold_valid <= 1'b0;
        end
    end

    assign out_array = hold_regs;
    assign out_valid = hold_valid;
`else
    assign release_vec = (state == FULL) && out_ready;
    assign out_array   = regs;
    assign out_valid   = (state == FULL);
`endif

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            FILL: begin
                if (accept) begin
                    count_next = count + CW'(1);
                    if (count == COUNT_LAST) begin
                        state_next = FULL;
                    end
                end
            end
            FULL: begin
                if (release_vec) begin
                    // A word accepted alongside the release starts the next vector.
                    count_next = accept ? CW'(1) : '0;
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FILL;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            state    <= FILL;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_gather.sv
// Bench for fifo_gather (DEPTH=4, BITS=8): directed vector table, async-reset case,
// then random traffic against a queue-based model. Follows FIFO_GATHER_DOUBLE_BUF_EN.
module tb_fifo_gather;

    localparam int DEPTH = 4;
    localparam int BITS  = 8;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        clr;
    logic                        en;
    logic [BITS-1:0]             d;
    logic                        in_ready;
    logic [DEPTH-1:0][BITS-1:0]  out_array;
    logic                        out_valid;
    logic                        out_ready;
    logic [2:0]                  count;
    logic                        overflow;

    int checks = 0;
    int errors = 0;

    fifo_gather #(
        .DEPTH (DEPTH),
        .BITS  (BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .en        (en),
        .d         (d),
        .in_ready  (in_ready),
        .out_array (out_array),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        en;
        logic [7:0]  d;
        logic        ordy;
        int          cnt;
        logic        val;
        logic        ir;
        logic        ovf;
        logic        chk_arr;
        logic [31:0] arr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic c, logic e, logic [7:0] dd, logic o, int n,
                                logic v, logic ir, logic ov, logic ca, logic [31:0] a);
        vec_t r;
        r.clr = c; r.en = e; r.d = dd; r.ordy = o; r.cnt = n;
        r.val = v; r.ir = ir; r.ovf = ov; r.chk_arr = ca; r.arr = a;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clr = 1'b0; en = 1'b0; d = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_array", 64'(out_array), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Reference model: shift bank as a queue of words, count, optional hold bank.
    logic [7:0] m_bank[$];
    logic [7:0] m_hold[$];
    int         m_n;
    bit         m_hv;
    bit         m_ovf;

    function automatic void m_reset();
        m_bank = {};
        m_hold = {};
        for (int i = 0; i < DEPTH; i++) begin
            m_bank.push_back(8'h00);
            m_hold.push_back(8'h00);
        end
        m_n = 0; m_hv = 0; m_ovf = 0;
    endfunction

    function automatic logic [31:0] pack(input logic [7:0] q[$]);
        logic [31:0] p = '0;
        for (int i = 0; i < DEPTH; i++) p[i*8 +: 8] = q[i];
        return p;
    endfunction

    function automatic bit m_in_ready(input bit ordy);
`ifdef FIFO_GATHER_DOUBLE_BUF_EN
        return (m_n < DEPTH) || !m_hv || ordy;
`else
        return (m_n < DEPTH) || ordy;
`endif
    endfunction

    function automatic bit m_valid();
`ifdef FIFO_GATHER_DOUBLE_BUF_EN
        return m_hv;
`else
        return m_n == DEPTH;
`endif
    endfunction

    function automatic logic [31:0] m_array();
`ifdef FIFO_GATHER_DOUBLE_BUF_EN
        return pack(m_hold);
`else
        return pack(m_bank);
`endif
    endfunction

    function automatic void m_step(input bit c, input bit e, input logic [7:0] dd, input bit ordy);
        bit acc;
        bit full;
        if (c) begin
            m_reset();
            return;
        end
        acc  = e && m_in_ready(ordy);
        full = (m_n == DEPTH);
        if (e && !acc) m_ovf = 1;
`ifdef FIFO_GATHER_DOUBLE_BUF_EN
        if (full && (!m_hv || ordy)) begin
            m_hold = m_bank;
            m_hv   = 1;
            m_n    = acc ? 1 : 0;
        end else begin
            if (m_hv && ordy) m_hv = 0;
            if (acc) m_n++;
        end
`else
        if (full && ordy) m_n = acc ? 1 : 0;
        else if (acc) m_n++;
`endif
        if (acc) begin
            void'(m_bank.pop_front());
            m_bank.push_back(dd);
        end
    endfunction

    initial begin
`ifdef FIFO_GATHER_DOUBLE_BUF_EN
        tbl.push_back(mk(0,1,8'h01,0, 0,0,1,0, 1,32'h0));
        tbl.push_back(mk(0,1,8'h02,0, 1,0,1,0, 0,32'h0));
        tbl.push_back(mk(0,1,8'h03,0, 2,0,1,0, 0,32'h0));
        tbl.push_back(mk(0,1,8'h04,0, 3,0,1,0, 0,32'h0));
        tbl.push_back(mk(0,1,8'h05,0, 4,0,1,0, 0,32'h0));
        tbl.push_back(mk(0,1,8'h06,0, 1,1,1,0, 1,32'h04030201));
        tbl.push_back(mk(0,1,8'h07,0, 2,1,1,0, 0,32'h0));
        tbl.push_back(mk(0,1,8'h08,0, 3,1,1,0, 0,32'h0));
        tbl.push_back(mk(0,1,8'h09,0, 4,1,0,0, 1,32'h04030201));
        tbl.push_back(mk(0,0,8'h00,1, 4,1,1,1, 1,32'h04030201));
        tbl.push_back(mk(0,0,8'h00,0, 0,1,1,1, 1,32'h08070605));
        tbl.push_back(mk(0,0,8'h00,1, 0,1,1,1, 1,32'h08070605));
        tbl.push_back(mk(1,1,8'hFF,0, 0,0,1,1, 0,32'h0));
        tbl.push_back(mk(0,0,8'h00,0, 0,0,1,0, 1,32'h0));
`else
        tbl.push_back(mk(0,1,8'h11,0, 0,0,1,0, 1,32'h0));
        tbl.push_back(mk(0,1,8'h22,0, 1,0,1,0, 0,32'h0));
        tbl.push_back(mk(0,1,8'h33,0, 2,0,1,0, 0,32'h0));
        tbl.push_back(mk(0,1,8'h44,0, 3,0,1,0, 0,32'h0));
        tbl.push_back(mk(0,1,8'h55,0, 4,1,0,0, 1,32'h44332211));
        tbl.push_back(mk(0,0,8'h00,0, 4,1,0,1, 1,32'h44332211));
        tbl.push_back(mk(0,1,8'hA0,1, 4,1,1,1, 1,32'h44332211));
        tbl.push_back(mk(0,1,8'hA1,0, 1,0,1,1, 0,32'h0));
        tbl.push_back(mk(0,1,8'hA2,0, 2,0,1,1, 0,32'h0));
        tbl.push_back(mk(0,1,8'hA3,0, 3,0,1,1, 0,32'h0));
        tbl.push_back(mk(0,0,8'h00,0, 4,1,0,1, 1,32'hA3A2A1A0));
        tbl.push_back(mk(1,1,8'hFF,0, 4,1,0,1, 1,32'hA3A2A1A0));
        tbl.push_back(mk(0,0,8'h00,0, 0,0,1,0, 1,32'h0));
        tbl.push_back(mk(0,1,8'h01,0, 0,0,1,0, 0,32'h0));
        tbl.push_back(mk(0,0,8'h00,0, 1,0,1,0, 0,32'h0));
        tbl.push_back(mk(0,1,8'h02,0, 1,0,1,0, 0,32'h0));
        tbl.push_back(mk(0,0,8'h00,0, 2,0,1,0, 0,32'h0));
        tbl.push_back(mk(0,1,8'h03,0, 2,0,1,0, 0,32'h0));
        tbl.push_back(mk(0,0,8'h00,0, 3,0,1,0, 0,32'h0));
        tbl.push_back(mk(0,1,8'h04,0, 3,0,1,0, 0,32'h0));
        tbl.push_back(mk(0,0,8'h00,1, 4,1,1,0, 1,32'h04030201));
        tbl.push_back(mk(0,0,8'h00,0, 0,0,1,0, 0,32'h0));
`endif

        do_reset();

        foreach (tbl[i]) begin
            clr = tbl[i].clr; en = tbl[i].en; d = tbl[i].d; out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].val));
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].ir));
            chk($sformatf("tbl%0d_overflow", i), 64'(overflow), 64'(tbl[i].ovf));
            if (tbl[i].chk_arr)
                chk($sformatf("tbl%0d_array", i), 64'(out_array), 64'(tbl[i].arr));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a fill.
        do_reset();
        clr = 1'b0; en = 1'b1; d = 8'h5A; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        en = 1'b0;
        #2;
        chk("midfill_count_before", 64'(count), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("midfill_count", 64'(count), 64'd0);
        chk("midfill_valid", 64'(out_valid), 64'd0);
        chk("midfill_array", 64'(out_array), 64'd0);
        chk("midfill_in_ready", 64'(in_ready), 64'd1);

        // Random traffic against the reference model.
        do_reset();
        m_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            clr       = ($urandom_range(0, 99) == 0);
            en        = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) == 0);
            d         = 8'($urandom);
            @(negedge clk);
            chk("rnd_in_ready", 64'(in_ready), 64'(m_in_ready(out_ready)));
            chk("rnd_valid", 64'(out_valid), 64'(m_valid()));
            chk("rnd_count", 64'(count), 64'(m_n));
            chk("rnd_overflow", 64'(overflow), 64'(m_ovf));
            chk("rnd_array", 64'(out_array), 64'(m_array()));
            m_step(clr, en, d, out_ready);
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_gather.md
Name: fifo_gather

Overview:
- Serial-in, parallel-out collector; the receive-side counterpart of the parallel-load/serial-shift feeder buffers.
- Captures one BITS-wide word per accepted cycle from a systolic-array row/column output.
- After DEPTH words, presents them as a parallel vector with valid/ready handshake toward the result writer.
- One instance per array output lane.

Parameters:
DEPTH, 8, number of words collected per vector (>=2)
BITS, 64, word width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
clr  in  1  synchronous clear: discard partial/held data, clear overflow
en  in  1  input word d offered this cycle
d  in  BITS  input word
in_ready  out  1  word accepted this cycle if en=1
out_array  out  BITS x [DEPTH]  collected vector; [0]=oldest word, [DEPTH-1]=newest
out_valid  out  1  out_array holds a complete vector
out_ready  in  1  consumer takes vector when out_valid=1
count  out  $clog2(DEPTH+1)  words held in shift bank (0..DEPTH)
overflow  out  1  sticky: en=1 while in_ready=0 (word dropped)

Behaviour:
- Reset (async): shift regs=0, count=0, state FILL, out_valid=0, in_ready=1, overflow=0; out_array=all 0.
- Accept = en & in_ready. Drop = en & ~in_ready: word discarded, overflow<=1 (sticky).
- Shift on accept: d enters regs[DEPTH-1], regs[i]<=regs[i+1]; after DEPTH accepts, first word sits at regs[0].
- out_array = regs directly (base build); partial contents are visible during FILL but are qualified only by out_valid.
- States (base build):
  - FILL: in_ready=1, out_valid=0. On accept: count++. Accept of the DEPTH-th word -> FULL; out_valid=1 the following cycle (latency 1 from last accept).
  - FULL: out_valid=1, count=DEPTH, in_ready=out_ready (combinational pass-through).
    - out_ready=1, en=0: count<=0, -> FILL.
    - out_ready=1, en=1: consume and accept the first word of the next vector in the same cycle; count<=1, -> FILL.
    - out_ready=0: hold; out_array stable; en drops words.
- Consume does not zero regs; only count/state change.
- clr: priority over all other sync events. Regs<=0, count<=0, -> FILL, out_valid<=0, overflow<=0; any en in that cycle is ignored and does not set overflow.
- Reset mid-operation: immediate return to reset values; the partial vector is lost.
- count never exceeds DEPTH; no wrap-around.

Optional Feature:
- Macro FIFO_GATHER_DOUBLE_BUF_EN.
- Defined: adds hold bank hold_regs[DEPTH] plus hold_valid.
  - out_array=hold_regs; out_valid=hold_valid.
  - Transfer when shift bank is FULL and (~hold_valid | out_ready): hold_regs<=regs, hold_valid<=1, count<=0 (or 1 if a word is accepted that cycle), -> FILL.
  - In FULL: in_ready = transfer condition.
  - Consume without transfer: hold_valid<=0.
  - Latency from DEPTH-th accept to out_valid = 2 cycles.
  - Collection continues while a vector waits downstream.
  - clr also clears hold_regs/hold_valid.
- Undefined: base behaviour above; no hold bank.

Decomposition:
- Shared package fifo_pkg:
  - gather_state_t enum {FILL, FULL}
  - localparam function for count width
- No sub-module required.
- Optional natural split: gather_bank (DEPTH x BITS register bank with shift and parallel-capture), reused for the shift and hold banks.

Test Plan (DEPTH=4, BITS=8):
- Reset, then en with d=0x11,0x22,0x33,0x44 on consecutive cycles, out_ready=0 -> cycle after 0x44: out_valid=1, out_array={[0]=0x11,[1]=0x22,[2]=0x33,[3]=0x44}, count=4, in_ready=0.
- Held FULL with en=1, d=0x55, out_ready=0 -> word dropped, overflow=1 and stays 1; out_array unchanged. Then clr -> overflow=0, count=0, out_valid=0.
- FULL with out_ready=1, en=1, d=0xA0 -> same-cycle consume; next cycle out_valid=0, count=1. After 0xA1,0xA2,0xA3 -> out_array={0xA0,0xA1,0xA2,0xA3}.
- Gapped input (en toggling 1,0,1,0,...) across 4 words -> count increments only on accepts; out_valid exactly 1 cycle after 4th accept.
- Assert rst_n low mid-fill (count=2) -> count=0, out_valid=0, out_array=0 asynchronously.
- With FIFO_GATHER_DOUBLE_BUF_EN, out_ready=0: feed 8 words 0x01..0x08 back-to-back -> out_valid 2 cycles after 0x04. out_array={0x01..0x04}; second vector collected, count=4, in_ready=0. Pulse out_ready -> next out_array={0x05..0x08}.
